seq_mult_unit: RTL
==================

Name: seq_mult_unit

Overview:
- Multi-cycle signed multiplier in the execute stage, directly downstream of the ALU controller.
- Starts on ALU control code 4'b0011 (mult) and runs an iterative radix-2 shift-add over WIDTH cycles.
- Produces a 2*WIDTH-bit product as hi/lo halves.
- Drives a stall to hold the pipeline while it is busy; all other control codes pass through to the combinational ALU untouched.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- MULT_CODE, 4'b0011, ALU control value that launches a multiply.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ctrl_i  input  4  ALU control code from the ALU controller.
- valid_i  input  1  the instruction in execute is valid this cycle.
- src1_i  input  WIDTH  multiplicand, two's complement.
- src2_i  input  WIDTH  multiplier, two's complement.
- flush_i  input  1  synchronous abort of any in-flight multiply.
- result_lo_o  output  WIDTH  low half of the product.
- result_hi_o  output  WIDTH  high half of the product.
- done_o  output  1  product valid; one-cycle pulse.
- busy_o  output  1  unit not in IDLE.
- stall_o  output  1  hold upstream pipeline registers.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0, all internal registers=0, result_lo_o=0, result_hi_o=0, done_o=0, busy_o=0, stall_o=0.
- start = valid_i && (ctrl_i==MULT_CODE) && state==IDLE && !flush_i.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start: latch |src1_i| and |src2_i| as unsigned magnitudes.
  - Latch sign flag = src1_i[WIDTH-1] ^ src2_i[WIDTH-1].
  - Clear the accumulator, set counter=0, go to CALC.
  - Magnitude of the most negative value is 2^(WIDTH-1), which is representable unsigned; no overflow special case.
- CALC, one iteration per cycle:
  - If multiplier LSB=1, add multiplicand to the upper accumulator half (WIDTH+1-bit add, carry kept).
  - Shift the {carry, accumulator, multiplier} register right by 1.
  - counter increments.
  - On the iteration where counter==WIDTH-1: register the final product, two's-complement negated over 2*WIDTH bits if the sign flag=1, into result_hi_o/result_lo_o; go to DONE.
- DONE: done_o=1 for exactly this cycle; return to IDLE on the next edge.
- Latency: accepting edge E0; results and done_o visible after edge E_WIDTH, i.e. WIDTH+1 edges after start was sampled; 33 edges for WIDTH=32.
- Result registers hold their value until the next product completes; they are not cleared on return to IDLE.
- busy_o = (state != IDLE).
- stall_o = start_cond || state==CALC, where start_cond is start without the state qualifier applied in IDLE.
  - stall_o is low in DONE so the pipeline advances in the same cycle done_o is high and captures the result.
- Inputs (ctrl_i, src*, valid_i) are ignored in CALC and DONE; operands are not re-sampled.
- flush_i=1 in any state: next edge forces IDLE; done_o stays 0; result registers keep their previous value; flush_i wins over start in the same cycle.
- Back-to-back mult: a new start is accepted only in IDLE, so the minimum issue interval is WIDTH+2 cycles.
- Non-MULT codes never start the unit and never assert stall_o.
- Reset asserted mid-CALC aborts immediately; all outputs go to their reset values.

Test Plan:
- 3 * 5, valid_i=1, ctrl_i=4'b0011 -> stall_o high for 33 cycles; done_o pulses at edge 33; hi=0x00000000, lo=0x0000000F.
- -7 * 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- 0x80000000 * 0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- ctrl_i=4'b0010 (add) with valid_i=1 -> busy_o, stall_o, done_o stay 0; results unchanged.
- Start 9*9 then flush_i at cycle 10 -> IDLE next edge, no done_o, prior results retained.
- Start 9*9 then rst_i low at cycle 10 -> all outputs 0 immediately, without waiting for a clock edge.
- Next mult after a flush runs to a correct result (12*12 -> lo=0x90).

Source files
------------

// File: rtl/seq_mult_if.sv
// Execute-stage multiplier bus.
// Groups the pipeline-facing signals of seq_mult_unit.
//   master : the pipeline side. It drives the control code, valid, operands and flush,
//            and it receives the product halves and the status flags.
//   slave  : the multiplier unit itself.
// The clock and reset are kept as plain ports on the unit, outside this bus.
interface seq_mult_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ctrl_i;       // ALU control code
    logic             valid_i;      // instruction in execute is valid
    logic [WIDTH-1:0] src1_i;       // multiplicand, two's complement
    logic [WIDTH-1:0] src2_i;       // multiplier, two's complement
    logic             flush_i;      // synchronous abort
    logic [WIDTH-1:0] result_lo_o;  // low half of the product
    logic [WIDTH-1:0] result_hi_o;  // high half of the product
    logic             done_o;       // one-cycle product-valid pulse
    logic             busy_o;       // unit not idle
    logic             stall_o;      // hold upstream pipeline registers

    modport master (
        output ctrl_i, valid_i, src1_i, src2_i, flush_i,
        input  result_lo_o, result_hi_o, done_o, busy_o, stall_o
    );

    modport slave (
        input  ctrl_i, valid_i, src1_i, src2_i, flush_i,
        output result_lo_o, result_hi_o, done_o, busy_o, stall_o
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Multi-cycle signed multiplier for the execute stage.
// It runs a radix-2 shift-add on the operand magnitudes for WIDTH cycles.
// It then applies the sign and registers a 2*WIDTH-bit product as hi/lo halves.
// Ports:
//   clk_i  : clock, rising edge.
//   rst_i  : asynchronous, active-low reset.
//   bus    : seq_mult_if.slave, which carries the control code, valid, operands,
//            flush, the hi/lo result, done, busy and stall.
module seq_mult_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] MULT_CODE = 4'b0011
) (
    input  logic       clk_i,
    input  logic       rst_i,
    seq_mult_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // Upper half is the accumulator; lower half starts as the multiplier and
    // fills with product bits as it shifts out.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               done_q, done_d;

    logic               start_cond, start;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shift_src;
    logic [2*WIDTH-1:0] prod_next, prod_final;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        done_d   = 1'b0;

        start_cond = bus.valid_i && (bus.ctrl_i == MULT_CODE) && !bus.flush_i;
        start      = start_cond && (state_q == IDLE);

        // The magnitude of the most negative value wraps to 2^(WIDTH-1).
        // That value is still correct when it is read as unsigned.
        mag1 = bus.src1_i[WIDTH-1] ? (~bus.src1_i + WIDTH'(1)) : bus.src1_i;
        mag2 = bus.src2_i[WIDTH-1] ? (~bus.src2_i + WIDTH'(1)) : bus.src2_i;

        // One shift-add step. The carry of the upper-half add is kept and shifted back in.
        sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        shift_src  = {sum, prod_q[WIDTH-1:0]};
        prod_next  = shift_src[2*WIDTH:1];
        prod_final = sign_q ? (~prod_next + (2*WIDTH)'(1)) : prod_next;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = mag1;
                    prod_d  = {{WIDTH{1'b0}}, mag2};
                    sign_d  = bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1];
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                prod_d  = prod_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH-1)) begin
                    res_hi_d = prod_final[2*WIDTH-1:WIDTH];
                    res_lo_d = prod_final[WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush beats everything, including a product finishing on the same edge.
        if (bus.flush_i) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
        end
    end

    // NOTE: every register here is reset, including the datapath. The reset
    // values are externally visible on the result ports, so they must be defined.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            done_q   <= done_d;
        end
    end

    assign bus.result_lo_o = res_lo_q;
    assign bus.result_hi_o = res_hi_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = (state_q != IDLE);
    // Stall is low in DONE, so the pipeline advances and captures the product.
    // It is also gated by reset, so all outputs sit at zero while reset is held.
    assign bus.stall_o     = rst_i && (((state_q == IDLE) && start_cond) || (state_q == CALC));

endmodule
